// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin share of one registered bitwise logic unit between two requesters
// Ports:
//   clk                      rising-edge clock
//   rst                      asynchronous active-low reset
//   reqN_valid / reqN_ready  request handshake for requester N (ready only in IDLE)
//   reqN_op                  00 AND, 01 OR, 10 XOR, 11 NOT(a)
//   reqN_a / reqN_b          operands (b ignored for NOT)
//   resp_valid / resp_ready  response handshake
//   resp_data / resp_id      result and owning requester, held until accepted
//   busy                     high while an operation is in EXEC or RESP
module logic_unit_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q;
  logic             prio_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic             resp_valid_q;
  logic [WIDTH-1:0] resp_data_q;
  logic             resp_id_q;
  logic             busy_q;
  logic             any_req;
  logic             gnt;
  logic             idle;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] result_d;
  always_comb begin
    any_req    = req0_valid | req1_valid;
    // prio only decides under contention; a lone requester always wins
    gnt        = (req0_valid & req1_valid) ? prio_q : req1_valid;
    // readies are masked while reset is held so every output reads 0
    idle       = rst & (state_q == IDLE) & any_req;
    req0_ready = idle & ~gnt;
    req1_ready = idle & gnt;
    op_sel     = gnt ? req1_op : req0_op;
    a_sel      = gnt ? req1_a : req0_a;
    b_sel      = gnt ? req1_b : req0_b;
    result_d   = (op_q == 2'b00) ? (a_q & b_q) :
                 (op_q == 2'b01) ? (a_q | b_q) :
                 (op_q == 2'b10) ? (a_q ^ b_q) : ~a_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          op_q    <= op_sel;
          a_q     <= a_sel;
          b_q     <= b_sel;
          id_q    <= gnt;
          prio_q  <= ~gnt;
          busy_q  <= 1'b1;
          state_q <= EXEC;
        end
        EXEC: begin
          resp_data_q  <= result_d;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed scoreboard bench for logic_unit_arbiter
module tb_logic_unit_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0, rr = 1'b1;
  logic [1:0] op0 = '0, op1 = '0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, e0 = '0, e1 = '0;
  logic rdy0, rdy1, rv, rid, bsy;
  logic [15:0] rd;
  int total = 0, fails = 0, cyc = 0, acc_cyc = 0, p = 0;
  logic mprio = 1'b0;
  typedef struct {logic id; logic [15:0] data;} exp_t;
  exp_t sb[$];
  logic [15:0] na[4] = '{16'h000B, 16'hF00F, 16'h0000, 16'hFFFF};
  logic [15:0] ne[4] = '{16'hFFF4, 16'h0FF0, 16'hFFFF, 16'h0000};

  logic_unit_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(rdy0), .req0_op(op0), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(rdy1), .req1_op(op1), .req1_a(a1), .req1_b(b1),
    .resp_valid(rv), .resp_ready(rr), .resp_data(rd), .resp_id(rid), .busy(bsy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set0(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
    op0 = op; a0 = a; b0 = b; e0 = e; v0 = 1'b1;
  endtask

  task automatic set1(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
    op1 = op; a1 = a; b1 = b; e1 = e; v1 = 1'b1;
  endtask

  task automatic accept_one();
    logic g;
    exp_t x;
    int n;
    g = (v0 && v1) ? mprio : v1;
    #1;
    n = 0;
    while (!(rdy0 || rdy1) && n < 10) begin
      tick();
      n++;
    end
    chk("ready0", rdy0, !g);
    chk("ready1", rdy1, g);
    x.id = g;
    x.data = g ? e1 : e0;
    sb.push_back(x);
    mprio = !g;
    tick();
    acc_cyc = cyc;
    if (g) v1 = 1'b0; else v0 = 1'b0;
    #1;
    chk("exec_busy", bsy, 1);
    chk("exec_resp_valid", rv, 0);
    chk("exec_ready0", rdy0, 0);
    chk("exec_ready1", rdy1, 0);
  endtask

  task automatic get_resp(input int hold);
    exp_t x;
    logic [15:0] d;
    tick();
    chk("latency_resp_valid", rv, 1);
    d = rd;
    if (hold > 0) rr = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_data", rd, d);
      chk("hold_valid", rv, 1);
      chk("hold_ready0", rdy0, 0);
      chk("hold_ready1", rdy1, 0);
      chk("hold_busy", bsy, 1);
    end
    rr = 1'b1;
    if (sb.size() > 0) x = sb.pop_front();
    else begin
      x.id = 1'bx;
      x.data = 'x;
    end
    chk("resp_data", rd, x.data);
    chk("resp_id", rid, x.id);
    tick();
    chk("post_resp_valid", rv, 0);
    chk("post_busy", bsy, 0);
    chk("post_data_kept", rd, d);
  endtask

  initial begin
    #12 rst = 1'b1;
    tick();
    chk("reset_resp_valid", rv, 0);
    chk("reset_busy", bsy, 0);
    // contention from reset: req0 first, then req1
    set0(2'b00, 16'hF00F, 16'h0FF0, 16'h0000);
    set1(2'b01, 16'hF000, 16'h000F, 16'hF00F);
    accept_one(); get_resp(0);
    accept_one(); get_resp(0);
    // next contention grants req0 again
    set0(2'b10, 16'h00FF, 16'h0F0F, 16'h0FF0);
    set1(2'b00, 16'h1234, 16'h00FF, 16'h0034);
    accept_one(); get_resp(0);
    accept_one(); get_resp(0);
    // NOT on req0
    set0(2'b11, 16'h000B, 16'h0000, 16'hFFF4);
    accept_one(); get_resp(0);
    // XOR on req1 with stalled consumer, req0 waiting
    set1(2'b10, 16'hFFFF, 16'hAAAA, 16'h5555);
    accept_one();
    set0(2'b00, 16'h1234, 16'hFF00, 16'h1200);
    get_resp(5);
    accept_one(); get_resp(0);
    // back-to-back NOTs from req0
    for (int i = 0; i < 4; i++) begin
      p = acc_cyc;
      set0(2'b11, na[i], 16'h0000, ne[i]);
      accept_one();
      if (i > 0) chk("accept_spacing", acc_cyc - p, 3);
      get_resp(0);
    end
    // reset mid-response
    set1(2'b01, 16'h0F00, 16'h00F0, 16'h0FF0);
    accept_one();
    rr = 1'b0;
    tick();
    chk("pre_reset_valid", rv, 1);
    rst = 1'b0;
    #2;
    chk("rst_resp_valid", rv, 0);
    chk("rst_resp_data", rd, 0);
    chk("rst_resp_id", rid, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_ready0", rdy0, 0);
    chk("rst_ready1", rdy1, 0);
    #13 rst = 1'b1;
    rr = 1'b1;
    sb.delete();
    mprio = 1'b0;
    tick();
    chk("after_rst_valid", rv, 0);
    set0(2'b01, 16'h0A0A, 16'hA0A0, 16'hAAAA);
    set1(2'b10, 16'h0F0F, 16'h00FF, 16'h0FF0);
    accept_one(); get_resp(0);
    accept_one(); get_resp(0);
    // reset during EXEC drops the op
    set0(2'b00, 16'hFFFF, 16'h00FF, 16'h00FF);
    accept_one();
    rst = 1'b0;
    #15;
    chk("exec_rst_valid", rv, 0);
    chk("exec_rst_busy", bsy, 0);
    rst = 1'b1;
    sb.delete();
    mprio = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dropped_no_valid", rv, 0);
    end
    set1(2'b10, 16'h0F0F, 16'hFFFF, 16'hF0F0);
    accept_one(); get_resp(0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
